pcie_7x_mgt_lane_seq: RTL and testbench

PCIE_7X_MGT_LANE_SEQ -- requirements
Module: pcie_7x_mgt_lane_seq

---
 rtl/pcie_7x_mgt_lane_seq.sv | 184 ++++++++++++++++++
 tb/tb_pcie_7x_mgt_lane_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_7x_mgt_lane_seq.sv
`default_nettype none
// ============================================================================
// Module   : pcie_7x_mgt_lane_seq
// Brief    : GT quad bring-up sequencer covering PLL lock wait, GT reset pulse,
//            reset-done wait, staggered lane enable, timeout retry and fault.
//            Optional registered status port: PCIE_7X_MGT_LANE_SEQ_STATUS_EN.
// Revision : 1.0  initial release
// ============================================================================
module pcie_7x_mgt_lane_seq #(
  parameter int C_LANES          = 4,
  parameter int C_RST_CYCLES     = 16,
  parameter int C_STAGGER_CYCLES = 8,
  parameter int C_TIMEOUT        = 1024,
  parameter int C_MAX_RETRY      = 3
) (
  input  logic               aclk,
  input  logic               reset,
  input  logic               start,
  input  logic               pll_lock,
  input  logic [C_LANES-1:0] resetdone,
  output logic               gt_reset,
  output logic [C_LANES-1:0] lane_en,
  output logic               ready,
  output logic               fault
`ifdef PCIE_7X_MGT_LANE_SEQ_STATUS_EN
  ,
  output logic [7:0]         status
`endif
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLL_WAIT  = 3'd1,
    S_GT_RST    = 3'd2,
    S_DONE_WAIT = 3'd3,
    S_LANE_UP   = 3'd4,
    S_READY     = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  localparam logic [15:0]        c_tmo_last  = 16'(C_TIMEOUT - 1);
  localparam logic [15:0]        c_rst_last  = 16'(C_RST_CYCLES - 1);
  localparam logic [7:0]         c_stg_last  = 8'(C_STAGGER_CYCLES - 1);
  localparam logic [2:0]         c_retry_max = 3'(C_MAX_RETRY);
  localparam logic [C_LANES-1:0] c_lane0     = C_LANES'(1);

  state_t             r_state;
  logic [15:0]        r_cnt;
  logic [7:0]         r_stg;
  logic [2:0]         r_retry;
  logic               r_gt_reset;
  logic [C_LANES-1:0] r_lane_en;
  logic               r_ready;
  logic               r_fault;

  state_t             w_next;
  logic [2:0]         w_retry_next;
  logic               w_fail;
  logic               w_tmo;
  logic               w_link_bad;
  logic               w_entry;
  logic [15:0]        w_cnt_next;
  logic [7:0]         w_stg_next;
  logic [C_LANES-1:0] w_lane_next;

  always_comb begin
    w_next       = r_state;
    w_retry_next = r_retry;
    w_fail       = 1'b0;
    w_tmo        = (r_cnt == c_tmo_last);
    w_link_bad   = !pll_lock || !(&resetdone);
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_PLL_WAIT;
      end
      S_PLL_WAIT: begin
        if (pll_lock)   w_next = S_GT_RST;
        else if (w_tmo) w_fail = 1'b1;
      end
      S_GT_RST: begin
        if (r_cnt == c_rst_last) w_next = S_DONE_WAIT;
      end
      S_DONE_WAIT: begin
        if (&resetdone) w_next = S_LANE_UP;
        else if (w_tmo) w_fail = 1'b1;
      end
      S_LANE_UP: begin
        if (w_link_bad)       w_fail = 1'b1;
        else if (&r_lane_en)  w_next = S_READY;
      end
      S_READY: begin
        if (w_link_bad) w_fail = 1'b1;
      end
      S_FAULT: begin
        w_next = S_FAULT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase

    // Timeouts and link loss share one retry path back through the GT reset
    if (w_fail) begin
      if (r_retry < c_retry_max) begin
        w_retry_next = r_retry + 3'd1;
        w_next       = S_GT_RST;
      end else begin
        w_next       = S_FAULT;
      end
    end

    if ((w_next == S_READY) && (r_state != S_READY)) w_retry_next = 3'd0;

    // Dropping start overrides everything, including a same-cycle timeout
    if (!start) begin
      w_next       = S_IDLE;
      w_retry_next = 3'd0;
    end
  end

  always_comb begin
    w_entry     = (w_next != r_state);
    w_cnt_next  = w_entry ? 16'd0 : ((r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1);
    w_lane_next = '0;
    w_stg_next  = 8'd0;
    if (w_next == S_LANE_UP) begin
      if (w_entry) begin
        w_lane_next = c_lane0;
      end else if (&r_lane_en) begin
        w_lane_next = r_lane_en;
      end else if (r_stg >= c_stg_last) begin
        w_lane_next = (r_lane_en << 1) | c_lane0;
      end else begin
        w_lane_next = r_lane_en;
        w_stg_next  = r_stg + 8'd1;
      end
    end else if (w_next == S_READY) begin
      w_lane_next = r_lane_en;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 16'd0;
      r_stg      <= 8'd0;
      r_retry    <= 3'd0;
      r_gt_reset <= 1'b0;
      r_lane_en  <= '0;
      r_ready    <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_next;
      r_stg      <= w_stg_next;
      r_retry    <= w_retry_next;
      r_gt_reset <= (w_next == S_GT_RST);
      r_lane_en  <= w_lane_next;
      r_ready    <= (r_state == S_READY) && (w_next == S_READY);
      r_fault    <= (w_next == S_FAULT);
    end
  end

  assign gt_reset = r_gt_reset;
  assign lane_en  = r_lane_en;
  assign ready    = r_ready;
  assign fault    = r_fault;

`ifdef PCIE_7X_MGT_LANE_SEQ_STATUS_EN
  logic [7:0] r_status;

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_status <= 8'd0;
    end else begin
      r_status <= {w_retry_next, 2'b00, w_next};
    end
  end

  assign status = r_status;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pcie_7x_mgt_lane_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_7x_mgt_lane_seq
// Brief    : Directed self-checking bench for pcie_7x_mgt_lane_seq (default
//            instance plus a 1-lane, zero-retry, short-timeout instance).
// Revision : 1.0  initial release
// ============================================================================
module tb_pcie_7x_mgt_lane_seq;

  logic       aclk = 1'b0;
  logic       reset;
  logic       start;
  logic       pll_lock;
  logic [3:0] resetdone;
  logic       gt_reset;
  logic [3:0] lane_en;
  logic       ready;
  logic       fault;

  logic       start1;
  logic       pll_lock1;
  logic [0:0] resetdone1;
  logic       gt_reset1;
  logic [0:0] lane_en1;
  logic       ready1;
  logic       fault1;

`ifdef PCIE_7X_MGT_LANE_SEQ_STATUS_EN
  logic [7:0] status;
  logic [7:0] status1;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 aclk = ~aclk;

  pcie_7x_mgt_lane_seq u_dut (
    .aclk      (aclk),
    .reset     (reset),
    .start     (start),
    .pll_lock  (pll_lock),
    .resetdone (resetdone),
    .gt_reset  (gt_reset),
    .lane_en   (lane_en),
    .ready     (ready),
    .fault     (fault)
`ifdef PCIE_7X_MGT_LANE_SEQ_STATUS_EN
    ,
    .status    (status)
`endif
  );

  pcie_7x_mgt_lane_seq #(
    .C_LANES          (1),
    .C_RST_CYCLES     (2),
    .C_STAGGER_CYCLES (1),
    .C_TIMEOUT        (4),
    .C_MAX_RETRY      (0)
  ) u_dut1 (
    .aclk      (aclk),
    .reset     (reset),
    .start     (start1),
    .pll_lock  (pll_lock1),
    .resetdone (resetdone1),
    .gt_reset  (gt_reset1),
    .lane_en   (lane_en1),
    .ready     (ready1),
    .fault     (fault1)
`ifdef PCIE_7X_MGT_LANE_SEQ_STATUS_EN
    ,
    .status    (status1)
`endif
  );

  task automatic tick();
    @(posedge aclk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cyc %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_lane;

    reset      = 1'b1;
    start      = 1'b0;
    pll_lock   = 1'b0;
    resetdone  = 4'h0;
    start1     = 1'b0;
    pll_lock1  = 1'b0;
    resetdone1 = 1'b0;
    tick();
    tick();
    chk("rst_gt_reset", {31'd0, gt_reset}, 32'd0);
    chk("rst_lane_en",  {28'd0, lane_en},  32'd0);
    chk("rst_ready",    {31'd0, ready},    32'd0);
    chk("rst_fault",    {31'd0, fault},    32'd0);

    // Nominal bring-up: cycle 0 is the first cycle with start=1
    reset     = 1'b0;
    start     = 1'b1;
    pll_lock  = 1'b1;
    resetdone = 4'hF;
    cyc       = 0;
    for (int c = 1; c <= 45; c++) begin
      tick();
      if (c < 19)      exp_lane = 4'h0;
      else if (c < 27) exp_lane = 4'h1;
      else if (c < 35) exp_lane = 4'h3;
      else if (c < 43) exp_lane = 4'h7;
      else             exp_lane = 4'hF;
      chk("up_gt_reset", {31'd0, gt_reset}, {31'd0, (c >= 2) && (c <= 17)});
      chk("up_lane_en",  {28'd0, lane_en},  {28'd0, exp_lane});
      chk("up_ready",    {31'd0, ready},    {31'd0, c >= 45});
    end

    // Momentary loss of one reset-done bit while READY
    resetdone = 4'hB;
    tick();
    resetdone = 4'hF;
    chk("drop_lane_en",  {28'd0, lane_en},       32'd0);
    chk("drop_ready",    {31'd0, ready},         32'd0);
    chk("drop_gt_reset", {31'd0, gt_reset},      32'd1);
    chk("drop_retry",    {29'd0, u_dut.r_retry}, 32'd1);
    go_to(45 + 17);
    chk("drop_gt_off",   {31'd0, gt_reset},      32'd0);
    go_to(45 + 42);
    chk("drop_lane_f",   {28'd0, lane_en},       32'hF);
    chk("drop_retry_hold", {29'd0, u_dut.r_retry}, 32'd1);
    go_to(45 + 43);
    chk("drop_retry_clr", {29'd0, u_dut.r_retry}, 32'd0);
    chk("drop_ready_lag", {31'd0, ready},         32'd0);
    go_to(45 + 44);
    chk("drop_ready_back", {31'd0, ready},        32'd1);

    // Reset mid LANE_UP with two lanes enabled
    start = 1'b0;
    tick();
    chk("idle_lane_en", {28'd0, lane_en}, 32'd0);
    chk("idle_ready",   {31'd0, ready},   32'd0);
    start = 1'b1;
    cyc   = 0;
    go_to(28);
    chk("lu_lane_en3", {28'd0, lane_en}, 32'h3);
    reset = 1'b1;
    tick();
    chk("lu_rst_lane_en",  {28'd0, lane_en},  32'd0);
    chk("lu_rst_gt_reset", {31'd0, gt_reset}, 32'd0);
    chk("lu_rst_ready",    {31'd0, ready},    32'd0);
    chk("lu_rst_fault",    {31'd0, fault},    32'd0);
    tick();
    tick();
    tick();
    chk("lu_hold_gt_reset", {31'd0, gt_reset},     32'd0);
    chk("lu_hold_lane_en",  {28'd0, lane_en},      32'd0);
    chk("lu_hold_retry",    {29'd0, u_dut.r_retry}, 32'd0);

    // PLL never locks: retries exhausted, then fault
    pll_lock  = 1'b0;
    resetdone = 4'h0;
    tick();
    reset = 1'b0;
    cyc   = 0;
    go_to(1024);
    chk("tmo_gt_pre",   {31'd0, gt_reset},      32'd0);
    go_to(1025);
    chk("tmo_gt_retry", {31'd0, gt_reset},      32'd1);
    chk("tmo_retry1",   {29'd0, u_dut.r_retry}, 32'd1);
    go_to(4144);
    chk("tmo_fault_pre", {31'd0, fault},        32'd0);
    chk("tmo_retry3",   {29'd0, u_dut.r_retry}, 32'd3);
    go_to(4145);
    chk("tmo_fault",    {31'd0, fault},         32'd1);
    chk("tmo_fault_gt", {31'd0, gt_reset},      32'd0);
    go_to(4148);
    chk("tmo_fault_sticky", {31'd0, fault},     32'd1);
    start = 1'b0;
    tick();
    chk("tmo_fault_clr", {31'd0, fault},        32'd0);
    chk("tmo_retry_clr", {29'd0, u_dut.r_retry}, 32'd0);

    // Timeout coincident with start deassertion
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b1;
    cyc   = 0;
    go_to(1024);
    start = 1'b0;
    tick();
    chk("coinc_gt_reset", {31'd0, gt_reset},      32'd0);
    chk("coinc_fault",    {31'd0, fault},         32'd0);
    chk("coinc_retry",    {29'd0, u_dut.r_retry}, 32'd0);

    // Single-lane, zero-retry instance: one timeout goes straight to fault
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    start1 = 1'b1;
    cyc    = 0;
    go_to(4);
    chk("one_fault_pre", {31'd0, fault1},    32'd0);
    go_to(5);
    chk("one_fault",     {31'd0, fault1},    32'd1);
    chk("one_fault_gt",  {31'd0, gt_reset1}, 32'd0);
`ifdef PCIE_7X_MGT_LANE_SEQ_STATUS_EN
    chk("one_status",    {24'd0, status1},   32'h06);
`endif
    start1 = 1'b0;
    tick();
    chk("one_fault_clr", {31'd0, fault1},    32'd0);

    // Single-lane nominal bring-up
    start1     = 1'b1;
    pll_lock1  = 1'b1;
    resetdone1 = 1'b1;
    cyc        = 0;
    go_to(3);
    chk("one_gt_reset",  {31'd0, gt_reset1}, 32'd1);
    go_to(5);
    chk("one_lane_en",   {31'd0, lane_en1},  32'd1);
    go_to(6);
    chk("one_ready_lag", {31'd0, ready1},    32'd0);
    go_to(7);
    chk("one_ready",     {31'd0, ready1},    32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
